// File: rtl/decoder_pkg.sv
// Shared types and the decode function for the registered index decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT   = 2'b00,
    DEC_THERM_LO = 2'b01,
    DEC_THERM_HI = 2'b10,
    DEC_RSVD     = 2'b11
  } dec_mode_t;

  // Widest output vector the function can build; callers slice the low bits.
  localparam int unsigned DEC_MAX_W = 64;

  typedef struct packed {
    logic                 err;
    logic [DEC_MAX_W-1:0] vec;
  } dec_res_t;

  // Bits at or above out_w are always zero. Out-of-range addresses fall out
  // of the bit rules naturally: one-hot and therm-high give zero, therm-low
  // saturates to all ones. The error flag ignores en.
  function automatic dec_res_t decode_vec(
    input logic [31:0] addr,
    input dec_mode_t   mode,
    input logic        en,
    input int unsigned out_w,
    input logic        zero_mask
  );
    dec_res_t res;
    logic     bit_v;
    res = '0;
    for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
      case (mode)
        DEC_ONEHOT:   bit_v = (i == addr);
        DEC_THERM_LO: bit_v = (i <= addr);
        DEC_THERM_HI: bit_v = (i >= addr);
        default:      bit_v = 1'b0;
      endcase
      if (en && (i < out_w)) res.vec[i] = bit_v;
    end
    if (zero_mask) res.vec[0] = 1'b0;
    res.err = (addr >= out_w) || (mode == DEC_RSVD);
    return res;
  endfunction

endpackage

// File: rtl/dec_skid_buffer.sv
// Generic 2-entry valid/ready buffer (main + skid), strictly FIFO.
// in_ready depends only on registered state and rst, so there is no
// combinational path from the downstream side back upstream.
module dec_skid_buffer #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  assign in_ready  = rst && !skid_vld_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_vld_q && out_ready;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;

  // Next-state: refill main from skid on drain, else park new data in skid.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_d = in_data;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (main_vld_q) begin
        skid_d     = in_data;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = in_data;
        main_vld_d = 1'b1;
      end
    end
  end

  // Registered state; reset empties both entries and zeroes the output word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/pipelined_decoder.sv
// Registered index decoder: one-hot / thermometer-low / thermometer-high,
// with optional bit-0 masking, behind a 2-entry skid buffer.
module pipelined_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W      = 5,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned ZERO_MASK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_addr,
  input  logic             in_en,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_dec,
  output logic             out_err
);

  dec_res_t         res_p0;
  logic [OUT_W:0]   payload_p0;
  logic [OUT_W:0]   payload_p1;

  // Stage 0: decode straight from the input before it is registered.
  always_comb begin
    res_p0     = decode_vec(32'(in_addr), dec_mode_t'(in_mode), in_en, OUT_W, ZERO_MASK != 0);
    payload_p0 = {res_p0.err, res_p0.vec[OUT_W-1:0]};
  end

  generate
    if (OUT_W < DEC_MAX_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^res_p0.vec[DEC_MAX_W-1:OUT_W];
    end
  endgenerate

  // Stage 1: registered payload leaves through the skid buffer.
  dec_skid_buffer #(
    .W (OUT_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payload_p0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (payload_p1)
  );

  assign out_err = payload_p1[OUT_W];
  assign out_dec = payload_p1[OUT_W-1:0];

endmodule

// File: tb/tb_pipelined_decoder.sv
// Bench for pipelined_decoder: three configurations driven in lockstep and
// checked every cycle against a queue-based reference model.
module tb_pipelined_decoder;

  typedef struct {
    int a;
    int m;
    bit e;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_addr = '0;
  logic        in_en = 1'b0;
  logic [1:0]  in_mode = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [31:0] out_dec_a, out_dec_b;
  logic [19:0] out_dec_c;
  logic        out_err_a, out_err_b, out_err_c;

  int          tests = 0;
  int          fails = 0;
  bit          started = 1'b0;
  txn_t        mq[$];
  logic [31:0] log_q[$];
  int          n_out = 0;

  always #5 clk = ~clk;

  pipelined_decoder #(.IN_W(5), .OUT_W(32), .ZERO_MASK(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_addr(in_addr), .in_en(in_en), .in_mode(in_mode),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_dec(out_dec_a), .out_err(out_err_a));

  pipelined_decoder #(.IN_W(5), .OUT_W(32), .ZERO_MASK(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_addr(in_addr), .in_en(in_en), .in_mode(in_mode),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_dec(out_dec_b), .out_err(out_err_b));

  pipelined_decoder #(.IN_W(5), .OUT_W(20), .ZERO_MASK(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_addr(in_addr), .in_en(in_en), .in_mode(in_mode),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_dec(out_dec_c), .out_err(out_err_c));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference decode in plain arithmetic; returns {err, vec}.
  function automatic logic [64:0] ref_dec(input int a, input int m, input bit e,
                                          input int w, input bit zm);
    logic [63:0] ones, v;
    bit          err;
    ones = (64'd1 << w) - 64'd1;
    err  = (a >= w) || (m == 3);
    case (m)
      0:       v = (a < w) ? (64'd1 << a) : 64'd0;
      1:       v = (a >= w) ? ones : ((64'd2 << a) - 64'd1);
      2:       v = (a >= w) ? 64'd0 : (ones & ~((64'd1 << a) - 64'd1));
      default: v = 64'd0;
    endcase
    if (!e) v = 64'd0;
    if (zm) v[0] = 1'b0;
    return {err, v};
  endfunction

  // Compare DUTs against the FIFO model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (started) begin
      bit          exp_vld, exp_rdy;
      logic [64:0] ea, eb, ec;
      exp_vld = (mq.size() > 0);
      exp_rdy = rst && (mq.size() < 2);
      check("in_ready", {61'b0, in_ready_a, in_ready_b, in_ready_c}, {61'b0, {3{exp_rdy}}});
      check("out_valid", {61'b0, out_valid_a, out_valid_b, out_valid_c}, {61'b0, {3{exp_vld}}});
      if (exp_vld) begin
        ea = ref_dec(mq[0].a, mq[0].m, mq[0].e, 32, 1'b0);
        eb = ref_dec(mq[0].a, mq[0].m, mq[0].e, 32, 1'b1);
        ec = ref_dec(mq[0].a, mq[0].m, mq[0].e, 20, 1'b1);
        check("dec_w32_nomask", {31'b0, out_err_a, out_dec_a}, {31'b0, ea[64], ea[31:0]});
        check("dec_w32_mask", {31'b0, out_err_b, out_dec_b}, {31'b0, eb[64], eb[31:0]});
        check("dec_w20_mask", {43'b0, out_err_c, out_dec_c}, {43'b0, ec[64], ec[19:0]});
      end
      if (!rst) begin
        mq.delete();
      end else begin
        if (exp_vld && out_ready) begin
          void'(mq.pop_front());
          log_q.push_back(out_dec_a);
          n_out++;
        end
        if (in_valid && exp_rdy) mq.push_back('{a: int'(in_addr), m: int'(in_mode), e: in_en});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int m, input bit e);
    bit acc;
    acc      = 1'b0;
    in_addr  = a[4:0];
    in_mode  = m[1:0];
    in_en    = e;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready_a;
      step();
    end
    in_valid = 1'b0;
    check("send_accept", {63'b0, acc}, 64'd1);
  endtask

  initial begin
    logic [64:0] r;
    int          n0;

    // Reset held for three edges.
    step();
    started = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready_a}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid_a}, 64'd0);
    check("rst_out_dec", {32'b0, out_dec_b}, 64'd0);
    check("rst_out_err", {63'b0, out_err_c}, 64'd0);

    // Hand-computed values pinning the reference model.
    r = ref_dec(0, 0, 1'b1, 32, 1'b1);  check("pin_oh_a0", {31'b0, r[64], r[31:0]}, 64'h0);
    r = ref_dec(5, 0, 1'b1, 32, 1'b1);  check("pin_oh_a5", {31'b0, r[64], r[31:0]}, 64'h20);
    r = ref_dec(3, 1, 1'b1, 32, 1'b1);  check("pin_tlo_a3", {31'b0, r[64], r[31:0]}, 64'hE);
    r = ref_dec(28, 2, 1'b1, 32, 1'b1); check("pin_thi_a28", {31'b0, r[64], r[31:0]}, 64'hF0000000);
    r = ref_dec(7, 0, 1'b0, 32, 1'b1);  check("pin_en0", {31'b0, r[64], r[31:0]}, 64'h0);
    r = ref_dec(25, 0, 1'b1, 20, 1'b1); check("pin_oor_oh", {43'b0, r[64], r[19:0]}, 64'h100000);
    r = ref_dec(25, 1, 1'b1, 20, 1'b1); check("pin_oor_tlo", {43'b0, r[64], r[19:0]}, 64'h1FFFFE);
    r = ref_dec(4, 3, 1'b1, 20, 1'b1);  check("pin_rsvd", {63'b0, r[64]}, 64'd1);

    // Sweep: one transaction per cycle, out_ready high.
    @(posedge clk); #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    log_q.delete();
    n0 = n_out;
    for (int a = 0; a < 32; a++) begin
      in_valid = 1'b1;
      in_addr  = a[4:0];
      in_mode  = 2'b00;
      in_en    = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("sweep_count", 64'(n_out - n0), 64'd32);
    for (int a = 0; a < 32; a++) check("sweep_val", {32'b0, log_q[a]}, 64'd1 << a);

    // Directed points from the mode rules.
    send(0, 0, 1'b1);
    send(5, 0, 1'b1);
    send(3, 1, 1'b1);
    send(28, 2, 1'b1);
    send(7, 0, 1'b0);
    send(25, 0, 1'b1);
    send(25, 1, 1'b1);
    send(9, 3, 1'b1);
    send(25, 2, 1'b0);
    step();
    step();

    // Backpressure: two accepted, third stalls until the sink drains.
    out_ready = 1'b0;
    step();
    log_q.delete();
    send(1, 0, 1'b1);
    send(2, 0, 1'b1);
    in_addr  = 5'd3;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", {63'b0, in_ready_a}, 64'd0);
      check("bp_dec_stable", {32'b0, out_dec_a}, 64'h2);
      step();
    end
    out_ready = 1'b1;
    send(3, 0, 1'b1);
    repeat (4) step();
    check("bp_count", 64'(log_q.size()), 64'd3);
    check("bp_first", {32'b0, log_q[0]}, 64'h2);
    check("bp_second", {32'b0, log_q[1]}, 64'h4);
    check("bp_third", {32'b0, log_q[2]}, 64'h8);

    // Reset with both entries full discards everything in flight.
    out_ready = 1'b0;
    send(10, 0, 1'b1);
    send(11, 0, 1'b1);
    rst = 1'b0;
    step();
    @(negedge clk);
    check("midrst_out_valid", {63'b0, out_valid_a}, 64'd0);
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    n0        = n_out;
    repeat (5) step();
    check("midrst_no_stale", 64'(n_out - n0), 64'd0);

    // Randomized traffic with random backpressure and occasional reset.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = 5'($urandom_range(0, 31));
      in_mode   = 2'($urandom_range(0, 3));
      in_en     = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 149) != 0);
      step();
    end
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_decoder.md
Name: pipelined_decoder

Overview:
- Parametrised, registered successor to the combinational 5-to-32 decoder in the MIPS datapath.
- Converts an IN_W-bit index into an OUT_W-bit vector in one of three modes: one-hot, thermometer-low or thermometer-high.
- Optional forcing of bit 0 to zero protects MIPS register $zero.
- Valid/ready handshake on both sides with a 2-entry skid buffer, so it sits between pipeline stages, e.g. decode to register-file write-enable.

Parameters:
IN_W, 5, index width in bits
OUT_W, 32, output vector width; legal range 1..2**IN_W
ZERO_MASK, 1, 1 forces out_dec[0]=0 in every mode

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  upstream transaction valid
in_ready  output  1  block can accept a transaction this cycle
in_addr  input  IN_W  index to decode
in_en  input  1  0 means decoded vector is all zeros; the transaction is still passed on
in_mode  input  2  00 one-hot, 01 thermometer-low, 10 thermometer-high, 11 reserved
out_valid  output  1  downstream transaction valid
out_ready  input  1  downstream accepts
out_dec  output  OUT_W  decoded vector
out_err  output  1  in_addr >= OUT_W or in_mode==11

Behaviour:
- Reset: rst sampled low at a clk edge clears both skid entries.
  - Reset values: out_valid=0, out_dec=0, out_err=0.
  - in_ready=0 combinationally while rst==0.
  - Reset mid-transfer discards in-flight data; nothing is emitted afterwards.
- Handshakes:
  - Input transfer when in_valid && in_ready at a clk edge.
  - Output transfer when out_valid && out_ready.
  - out_dec and out_err stay stable while out_valid && !out_ready.
- Decode function, computed from the input before registering (with a = in_addr):
  - one-hot: bit i = (i==a).
  - thermometer-low: bit i = (i<=a).
  - thermometer-high: bit i = (i>=a).
  - in_en=0: all zeros.
  - ZERO_MASK=1: bit 0 cleared after the mode logic.
- Error:
  - a >= OUT_W gives out_dec=0 and out_err=1, except thermometer-low, which saturates to all-ones (masked per ZERO_MASK) with out_err=1.
  - in_mode==11 gives out_dec=0 and out_err=1.
  - Error is reported even when in_en=0.
- Latency: exactly 1 cycle from input transfer to out_valid when the buffer is empty.
- Throughput: 1 transaction per cycle while out_ready stays high.
- Skid buffer: 2 entries, main and skid; ordering is strictly FIFO.
  - in_ready = !skid_full, registered-state driven.
  - Input transfer while the main entry holds data and out_ready==0: data goes to the skid entry.
  - Main entry transfers out: the skid entry moves to main in the same edge.
  - Simultaneous input transfer and output transfer with both entries full cannot occur, because in_ready==0.
  - Simultaneous input and output transfer with only main full: main is replaced by the new data; skid stays empty.
- Empty buffer: out_valid=0 and out_dec holds its last value. The bench must not check out_dec while out_valid==0.
- No combinational path from in_* to out_*. in_ready depends only on state and rst.

Decomposition:
- Package decoder_pkg holds:
  - typedef enum logic [1:0] dec_mode_t: DEC_ONEHOT, DEC_THERM_LO, DEC_THERM_HI, DEC_RSVD.
  - Parameterised function decode_vec(addr, mode, en), returning vector and err.
- Sub-module dec_skid_buffer: generic 2-entry valid/ready buffer parametrised on payload width (OUT_W+1). Reusable for later pipeline registers.
- Top module contains decode logic plus one dec_skid_buffer instance.

Test Plan:
- Reset and sweep:
  - Hold rst=0 for 3 cycles -> out_valid=0, in_ready=0.
  - Release, one-hot, en=1, ZERO_MASK=0, a=0..31 streamed with out_ready=1 -> out_dec=1<<a, 1-cycle latency, 32 outputs in 32 consecutive cycles.
- ZERO_MASK=1, one-hot:
  - a=0 -> out_dec=32'h0, out_err=0.
  - a=5 -> 32'h00000020.
- Thermometer:
  - therm-lo a=3 -> 32'h0000000E (mask on).
  - therm-hi a=28 -> 32'hF0000000.
  - en=0, a=7 -> 32'h0.
- Out-of-range, OUT_W=20, IN_W=5:
  - one-hot a=25 -> out_dec=0, out_err=1.
  - therm-lo a=25 -> 20'hFFFFE, out_err=1.
  - mode 11 -> out_err=1.
- Backpressure:
  - out_ready=0, send a=1,2,3 -> in_ready falls after the 2nd accept; 3rd held.
  - Then out_ready=1 -> outputs 2,4,8 in order, no loss or duplication.
- Reset mid-operation:
  - Fill both entries, assert rst=0 for 1 cycle -> out_valid=0 next cycle; no stale output after release.
